// File: rtl/lon_pkg.sv
// Shared geometry and stage payload for the leading-one normalizer.
package lon_pkg;

  localparam int unsigned LON_WIDTH = 8;
  localparam int unsigned LON_TAG_W = 4;
  localparam int unsigned POS_W     = $clog2(LON_WIDTH);

  typedef struct packed {
    logic [LON_WIDTH-1:0] value;
    logic                 invert;
    logic [LON_TAG_W-1:0] tag;
    logic [POS_W-1:0]     position;
    logic                 found;
  } lon_stage_t;

endpackage

// File: rtl/lod_priority_encoder.sv
// MSB-first priority encoder: index of the highest set bit, 0 when none set.
module lod_priority_encoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH)-1:0] position,
  output logic                     found
);

  localparam int unsigned POS_W = $clog2(WIDTH);

  // Ascending scan: a later (higher) set bit overwrites any lower one.
  always_comb begin
    position = '0;
    found    = |value;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (value[i]) position = POS_W'(i);
    end
  end

endmodule

// File: rtl/leading_one_normalizer.sv
// Two-stage leading-one/zero detect and normalize with valid/ready flow control.
module leading_one_normalizer
  import lon_pkg::*;
#(
  parameter int unsigned WIDTH = LON_WIDTH,
  parameter int unsigned TAG_W = LON_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_invert,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_position,
  output logic             out_found,
  output logic [POS_W-1:0] out_shift,
  output logic [WIDTH-1:0] out_normalized,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  lon_stage_t       s1_q;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] scan_word;
  logic [POS_W-1:0] enc_position;
  logic             enc_found;
  logic [POS_W-1:0] shift_c;
  logic [WIDTH-1:0] normalized_c;

  assign scan_word = in_invert ? ~in_value : in_value;

  lod_priority_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .value    (scan_word),
    .position (enc_position),
    .found    (enc_found)
  );

  // A stage moves forward only into an empty or simultaneously draining slot.
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = rst_n & (~s1_valid | s2_load);
  assign s1_load  = in_valid & in_ready;

  // No match leaves the word untouched; the shift always uses the unscanned value.
  assign shift_c      = s1_q.found ? (POS_W'(WIDTH - 1) - s1_q.position) : '0;
  assign normalized_c = s1_q.value << shift_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_q.value    <= in_value;
        s1_q.invert   <= in_invert;
        s1_q.tag      <= in_tag;
        s1_q.position <= enc_position;
        s1_q.found    <= enc_found;
      end
      s1_valid <= s1_load | (s1_valid & ~s2_load);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_position   <= '0;
      out_found      <= 1'b0;
      out_shift      <= '0;
      out_normalized <= '0;
      out_tag        <= '0;
    end else begin
      if (s2_load) begin
        out_position   <= s1_q.position;
        out_found      <= s1_q.found;
        out_shift      <= shift_c;
        out_normalized <= normalized_c;
        out_tag        <= s1_q.tag;
      end
      out_valid <= s2_load | (out_valid & ~out_ready);
    end
  end

endmodule
